// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage of the 16-bit single-issue CPU. Keeps the program
//   counter, fetches one instruction word per request over a ready-handshaked
//   memory port, holds it in the instruction register and exposes the decoded
//   fields. A retiring instruction may redirect the next PC (jump / branch).
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   mem_read     out  fetch request, high for the whole FETCH state
//   mem_addr     out  fetch address (the PC)
//   mem_data     in   instruction word, valid with mem_ready
//   mem_ready    in   memory data-valid strobe
//   stall        in   downstream busy; the held instruction does not retire
//   redirect     in   retiring instruction changes flow
//   redirect_pc  in   next PC when redirect is high
//   instr_valid  out  instr and decoded fields are valid
//   instr        out  instruction register
//   opcode/rs/rt/rd/func/imm/target  out  combinational slices of instr
//   pc_out       out  PC of the held instruction
//   pc_plus1     out  pc_out + 1 (JAL link value), wraps
//   num_inst     out  retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000,
    parameter int                   COUNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_ready,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr,
    output logic [3:0]           opcode,
    output logic [1:0]           rs,
    output logic [1:0]           rt,
    output logic [1:0]           rd,
    output logic [5:0]           func,
    output logic [7:0]           imm,
    output logic [11:0]          target,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] pc_plus1,
    output logic [COUNT_W-1:0]   num_inst
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_ir;
    logic [COUNT_W-1:0]   r_num_inst;
    logic                 w_capture;
    logic                 w_retire;

    // Handshake completes only while a request is outstanding; a retire only
    // happens from HOLD with the consumer not stalled.
    assign w_capture = (r_state == S_FETCH) && mem_ready;
    assign w_retire  = (r_state == S_HOLD) && !stall;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_next_state = S_HOLD;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Program counter: advances or takes the redirect target on retire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (w_retire) begin
            if (redirect) begin
                r_pc <= redirect_pc;
            end else begin
                r_pc <= r_pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
            end
        end else begin
            r_pc <= r_pc;
        end
    end

    // Instruction register: loaded only on the handshake edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= {WORD_SIZE{1'b0}};
        end else if (w_capture) begin
            r_ir <= mem_data;
        end else begin
            r_ir <= r_ir;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_inst <= {COUNT_W{1'b0}};
        end else if (w_retire) begin
            r_num_inst <= r_num_inst + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_num_inst <= r_num_inst;
        end
    end

    // Request/valid are pure state decodes so no input reaches them combinationally.
    assign mem_read    = (r_state == S_FETCH);
    assign mem_addr    = r_pc;
    assign instr_valid = (r_state == S_HOLD);

    assign instr    = r_ir;
    assign opcode   = r_ir[15:12];
    assign rs       = r_ir[11:10];
    assign rt       = r_ir[9:8];
    assign rd       = r_ir[7:6];
    assign func     = r_ir[5:0];
    assign imm      = r_ir[7:0];
    assign target   = r_ir[11:0];
    assign pc_out   = r_pc;
    assign pc_plus1 = r_pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    assign num_inst = r_num_inst;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch: directed scenario tasks followed by a
//   randomized run, all compared against a behavioural model of the fetch
//   stage (request outstanding / instruction held, pc, ir, retire count).
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        instr_valid;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [1:0]  rs, rt, rd;
    logic [5:0]  func;
    logic [7:0]  imm;
    logic [11:0] target;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1;
    logic [15:0] num_inst;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_cnt;
    bit          m_req;   // a fetch request is outstanding
    bit          m_hold;  // an instruction is being held

    instr_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .func        (func),
        .imm         (imm),
        .target      (target),
        .pc_out      (pc_out),
        .pc_plus1    (pc_plus1),
        .num_inst    (num_inst)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc   = 16'h0000;
        m_ir   = 16'h0000;
        m_cnt  = 16'h0000;
        m_req  = 1'b0;
        m_hold = 1'b0;
    endtask

    // Apply the rules of one rising edge to the model using current inputs.
    task automatic model_edge();
        if (!m_req && !m_hold) begin
            m_req = 1'b1;
        end else if (m_req) begin
            if (mem_ready) begin
                m_ir   = mem_data;
                m_req  = 1'b0;
                m_hold = 1'b1;
            end
        end else if (!stall) begin
            m_cnt  = m_cnt + 16'd1;
            m_pc   = redirect ? redirect_pc : m_pc + 16'd1;
            m_hold = 1'b0;
            m_req  = 1'b1;
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_read, instr_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: mem_read=%0b instr_valid=%0b expected 0 0", mem_read, instr_valid);
        end
        checks++;
        if (pc_out !== 16'h0000 || num_inst !== 16'h0000) begin
            errors++;
            $display("FAIL reset_regs: pc_out=%h num_inst=%h expected 0000 0000", pc_out, num_inst);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: mem_read=%0b expected 0", mem_read);
        end
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_first_req: mem_read=%0b mem_addr=%h expected 1 0000", mem_read, mem_addr);
        end
    endtask

    task automatic test_zero_wait();
        mem_ready = 1'b1;
        mem_data  = 16'h4A3F;
        stall     = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL zw_valid: instr_valid=%0b mem_read=%0b expected 1 0", instr_valid, mem_read);
        end
        checks++;
        if ({opcode, rs, rt, rd, func} !== {4'd4, 2'd2, 2'd2, 2'd0, 6'h3F}) begin
            errors++;
            $display("FAIL zw_fields: op=%h rs=%0d rt=%0d rd=%0d func=%h expected 4 2 2 0 3f",
                     opcode, rs, rt, rd, func);
        end
        checks++;
        if (imm !== 8'h3F || target !== 12'hA3F) begin
            errors++;
            $display("FAIL zw_imm_target: imm=%h target=%h expected 3f a3f", imm, target);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h0001 || num_inst !== 16'd1) begin
            errors++;
            $display("FAIL zw_retire: mem_read=%0b mem_addr=%h num_inst=%0d expected 1 0001 1",
                     mem_read, mem_addr, num_inst);
        end
    endtask

    task automatic test_wait_states();
        mem_ready = 1'b0;
        mem_data  = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== 16'h0001 || instr !== 16'h4A3F) begin
                errors++;
                $display("FAIL ws_wait%0d: mem_read=%0b mem_addr=%h instr=%h expected 1 0001 4a3f",
                         i, mem_read, mem_addr, instr);
            end
            if (i < 3) tick();
        end
        mem_ready = 1'b1;
        tick();
        checks++;
        if (instr !== 16'h1234 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL ws_capture: instr=%h instr_valid=%0b expected 1234 1", instr, instr_valid);
        end
        stall    = 1'b1;
        mem_data = 16'hBEEF;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (instr !== 16'h1234) begin
            errors++;
            $display("FAIL ws_spurious: instr=%h expected 1234", instr);
        end
    endtask

    task automatic test_stall();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (instr !== 16'h1234 || pc_out !== 16'h0001 || num_inst !== 16'd1 ||
                mem_read !== 1'b0 || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: instr=%h pc=%h cnt=%0d rd=%0b v=%0b expected 1234 0001 1 0 1",
                         i, instr, pc_out, num_inst, mem_read, instr_valid);
            end
        end
        stall    = 1'b0;
        redirect = 1'b0;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h0002 || num_inst !== 16'd2) begin
            errors++;
            $display("FAIL stall_release: mem_read=%0b mem_addr=%h num_inst=%0d expected 1 0002 2",
                     mem_read, mem_addr, num_inst);
        end
    endtask

    task automatic test_redirect_wrap();
        mem_ready = 1'b1;
        mem_data  = 16'($urandom);
        tick();
        mem_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        checks++;
        if (mem_addr !== 16'h0040 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL redirect_addr: mem_addr=%h mem_read=%0b expected 0040 1", mem_addr, mem_read);
        end
        mem_ready = 1'b1;
        tick();
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if (pc_out !== 16'hFFFF || pc_plus1 !== 16'h0000 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_plus1: pc_out=%h pc_plus1=%h valid=%0b expected ffff 0000 1",
                     pc_out, pc_plus1, instr_valid);
        end
        tick();
        checks++;
        if (mem_addr !== 16'h0000 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL wrap_fetch: mem_addr=%h mem_read=%0b expected 0000 1", mem_addr, mem_read);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mem_ready   = ($urandom_range(0, 2) != 0);
            mem_data    = 16'($urandom);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 3) == 0);
            redirect_pc = 16'($urandom);
            tick();
            checks++;
            if (mem_read !== m_req || instr_valid !== m_hold || pc_out !== m_pc ||
                mem_addr !== m_pc || pc_plus1 !== m_pc + 16'd1 || num_inst !== m_cnt) begin
                errors++;
                $display("FAIL rand_ctrl%0d: rd=%0b v=%0b pc=%h addr=%h p1=%h cnt=%h expected %0b %0b %h %h %h %h",
                         i, mem_read, instr_valid, pc_out, mem_addr, pc_plus1, num_inst,
                         m_req, m_hold, m_pc, m_pc, m_pc + 16'd1, m_cnt);
            end
            if (m_hold) begin
                checks++;
                if (instr !== m_ir || {opcode, rs, rt, rd, func} !== m_ir ||
                    imm !== m_ir[7:0] || target !== m_ir[11:0]) begin
                    errors++;
                    $display("FAIL rand_instr%0d: instr=%h imm=%h target=%h expected %h",
                             i, instr, imm, target, m_ir);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        stall     = 1'b0;
        redirect  = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 4 && !m_req; i++) tick();
        checks++;
        if (mem_read !== 1'b1 || m_req !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup: mem_read=%0b model_req=%0b expected 1 1", mem_read, m_req);
        end
        #2;
        mem_ready = 1'b1;
        mem_data  = 16'hC0DE;
        reset_n   = 1'b0;
        model_reset();
        #1;
        checks++;
        if (mem_read !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 16'h0000 || num_inst !== 16'h0000) begin
            errors++;
            $display("FAIL arst_immediate: rd=%0b v=%0b pc=%h cnt=%h expected 0 0 0000 0000",
                     mem_read, instr_valid, pc_out, num_inst);
        end
        @(posedge clk);
        #1;
        checks++;
        if (instr !== 16'h0000 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL arst_discard: instr=%h mem_read=%0b expected 0000 0", instr, mem_read);
        end
        mem_ready = 1'b0;
        reset_n   = 1'b1;
        #1;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL arst_restart: mem_read=%0b mem_addr=%h expected 1 0000", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        mem_data  = 16'h7E01;
        tick();
        checks++;
        if (instr !== 16'h7E01 || pc_out !== 16'h0000 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_refetch: instr=%h pc=%h v=%0b expected 7e01 0000 1", instr, pc_out, instr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_wrap();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the 16-bit single-issue CPU. Maintains the program counter and fetches one instruction word per request over a ready-handshaked memory port. Holds the fetched word in an instruction register and presents the decoded fields (opcode, func, register indices, immediates) to the Control unit and the datapath. Accepts a next-PC redirect from jump and branch resolution.

## Interface
- WORD_SIZE, 16, width of instructions, addresses and PC
- RESET_PC, 16'h0000, PC value loaded on reset
- COUNT_W, 16, width of the retired-instruction counter
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- mem_read  out  1  fetch request, high for the whole fetch
- mem_addr  out  WORD_SIZE  fetch address; equals the PC
- mem_data  in  WORD_SIZE  instruction word, valid when mem_ready is high
- mem_ready  in  1  memory data-valid strobe
- stall  in  1  downstream busy; the held instruction must not retire
- redirect  in  1  the retiring instruction changes flow
- redirect_pc  in  WORD_SIZE  next PC when redirect is high
- instr_valid  out  1  instr and the decoded fields are valid
- instr  out  WORD_SIZE  instruction register
- opcode  out  4  instr[15:12]
- rs, rt, rd  out  2 each  instr[11:10], instr[9:8], instr[7:6]
- func  out  6  instr[5:0]
- imm  out  8  instr[7:0], raw; sign extension is done downstream
- target  out  12  instr[11:0]
- pc_out  out  WORD_SIZE  PC of the held instruction
- pc_plus1  out  WORD_SIZE  pc_out + 1, modulo 2^WORD_SIZE; used as the JAL link value
- num_inst  out  COUNT_W  count of retired instructions

## Operation
- **States:** IDLE, FETCH, HOLD.
- **Reset** (reset_n low, asynchronous):
  - state = IDLE, pc = RESET_PC, ir = 0, num_inst = 0.
  - Resulting outputs: mem_read = 0, instr_valid = 0.
- **IDLE:** goes to FETCH on the next edge unconditionally.
- **FETCH:**
  - mem_read = 1 and mem_addr = pc, both held stable until the handshake completes.
  - On the edge with mem_ready = 1: ir <= mem_data and state -> HOLD.
  - Otherwise the block stays in FETCH with no limit on wait states.
- **HOLD:**
  - instr_valid = 1 and mem_read = 0.
  - Edge with stall = 1: no change. redirect is ignored.
  - Edge with stall = 0 (retire): num_inst increments, pc <= redirect ? redirect_pc : pc + 1, state -> FETCH.
- **pc arithmetic** wraps modulo 2^WORD_SIZE: 16'hFFFF + 1 = 16'h0000.
- **num_inst** wraps modulo 2^COUNT_W.
- **Ignored inputs:**
  - mem_ready in IDLE or HOLD; mem_data is not captured.
  - redirect and redirect_pc outside a retire edge.
- **Output gating:** decoded fields are combinational slices of ir. Consumers (Control, register file write enable, output port) must gate on instr_valid. Field values are don't-care while instr_valid = 0.
- **Output timing:** mem_read, mem_addr and instr_valid depend only on state and registers. None of them depends combinationally on any input.

## Timing
- The first fetch request appears 1 cycle after reset_n deasserts (the IDLE cycle).
- Minimum fetch latency: when mem_ready is high in the first FETCH cycle, instr_valid rises on the next cycle.
- Peak throughput is 1 instruction per 2 cycles (FETCH + HOLD), plus memory wait states and stall cycles.
- The retire edge and the new request are adjacent: the cycle after a retire, mem_read = 1 and mem_addr shows the new pc.
- pc_out and pc_plus1 stay stable for the whole HOLD period and during the following FETCH show the new pc.
- Reset asserted mid-FETCH or mid-HOLD:
  - Outputs go to their reset values immediately, without a clock edge.
  - An in-flight memory response is discarded.

## Test plan
- **Reset release:** hold reset_n low for 3 cycles, then release.
  - During reset: mem_read = 0, instr_valid = 0, pc_out = 0, num_inst = 0.
  - First cycle after release: mem_read = 0.
  - Second cycle after release: mem_read = 1, mem_addr = 0.
- **Zero-wait fetch:** mem_ready tied high, mem_data = 16'h4A3F, stall = 0.
  - Held cycle: instr_valid = 1, opcode = 4, rs = 2, rt = 2, rd = 0, func = 6'h3F, imm = 8'h3F, target = 12'hA3F.
  - Next request: mem_addr = 1.
  - Retirement: num_inst = 1.
- **Wait states:** delay mem_ready by 3 cycles.
  - mem_read stays 1 and mem_addr stays constant for 4 cycles.
  - instr is unchanged until the capture edge.
  - A spurious mem_ready pulse in HOLD does not alter instr.
- **Stall:** stall = 1 for 4 HOLD cycles, with redirect = 1 and redirect_pc = 16'h0040 asserted throughout.
  - instr, pc_out and num_inst stay constant, and no request is made.
  - Release stall with redirect = 0: next mem_addr = pc + 1.
- **Redirect and wrap:**
  - Retire with redirect = 1, redirect_pc = 16'h0040: next mem_addr = 16'h0040.
  - With pc = 16'hFFFF: pc_plus1 = 16'h0000, and a non-redirect retire fetches address 0.
- **Asynchronous reset:** pull reset_n low mid-FETCH, between clock edges.
  - mem_read drops immediately, and pc_out = RESET_PC.
  - After release, the fetch restarts at RESET_PC.
